seven_seg_scan_driver: RTL

Parametrised multi-digit seven-segment display driver. It time-multiplexes NUM_DIGITS hex digits onto one shared cathode bus and a one-hot anode bus. It adds features the single-digit decoder lacks: a hold register, per-digit decimal point and blanking, leading-zero suppression, an inter-digit ghosting guard, and selectable output polarity. It sits between the datapath's debug/status values and the board's display pins.

---
 rtl/seven_seg_scan_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multi-digit seven-segment scan driver: hold register, per-digit dp and blanking,
// leading-zero suppression, anti-ghosting guard and selectable pin polarity.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS     = 8,
   parameter int REFRESH_CYCLES = 100000,
   parameter int GUARD_CYCLES   = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [4*NUM_DIGITS-1:0] val_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic                    lz_suppress_in,
   input  logic                    load_in,
   output logic [6:0]              cat_out,
   output logic                    dp_out,
   output logic [NUM_DIGITS-1:0]   an_out,
   output logic                    scan_wrap_out
);

   localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CNT_W:0]   GUARD_END = (CNT_W + 1)'(GUARD_CYCLES);

   // Active-high segment pattern, bit0=a ... bit6=g.
   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         4'hF:    seg = 7'h71;
         default: seg = 7'h00;
      endcase
      return seg;
   endfunction

   logic [4*NUM_DIGITS-1:0] val_r;
   logic [NUM_DIGITS-1:0]   dp_r;
   logic [NUM_DIGITS-1:0]   blank_r;
   logic                    lz_r;
   logic [CNT_W-1:0]        cnt_r;
   logic [IDX_W-1:0]        idx_r;
   logic                    wrap_r;

   logic [3:0]              nib_s;
   logic                    dp_sel_s;
   logic                    dark_s;
   logic                    zero_run_s;
   logic                    guard_s;
   logic [NUM_DIGITS-1:0]   an_sel_s;
   logic [6:0]              seg_s;

   // Hold register: display content only ever comes from here.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         val_r   <= {(4*NUM_DIGITS){1'b0}};
         dp_r    <= {NUM_DIGITS{1'b0}};
         blank_r <= {NUM_DIGITS{1'b0}};
         lz_r    <= 1'b0;
      end else if (load_in) begin
         val_r   <= val_in;
         dp_r    <= dp_in;
         blank_r <= blank_in;
         lz_r    <= lz_suppress_in;
      end else begin
         val_r   <= val_r;
         dp_r    <= dp_r;
         blank_r <= blank_r;
         lz_r    <= lz_r;
      end
   end

   // Dwell counter and digit index; wrap_r marks the return to digit 0.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_r  <= {CNT_W{1'b0}};
         idx_r  <= {IDX_W{1'b0}};
         wrap_r <= 1'b0;
      end else if (cnt_r == CNT_MAX) begin
         cnt_r  <= {CNT_W{1'b0}};
         idx_r  <= (idx_r == IDX_MAX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
         wrap_r <= (idx_r == IDX_MAX);
      end else begin
         cnt_r  <= cnt_r + CNT_W'(1);
         idx_r  <= idx_r;
         wrap_r <= 1'b0;
      end
   end

   // Select the current digit; zero_run_s tracks "this and all higher nibbles are zero".
   always_comb begin
      nib_s      = 4'h0;
      dp_sel_s   = 1'b0;
      dark_s     = 1'b0;
      zero_run_s = 1'b1;
      an_sel_s   = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run_s  = zero_run_s & (val_r[4*i +: 4] == 4'h0);
         an_sel_s[i] = (idx_r == IDX_W'(i));
         nib_s       = nib_s | (val_r[4*i +: 4] & {4{an_sel_s[i]}});
         dp_sel_s    = dp_sel_s | (dp_r[i] & an_sel_s[i]);
         dark_s      = dark_s | (an_sel_s[i] & (blank_r[i] | (lz_r & zero_run_s & (i != 0))));
      end
      guard_s = ({1'b0, cnt_r} < GUARD_END);
      seg_s   = dark_s ? 7'h00 : hex_font(nib_s);
   end

   // Registered pins; XOR applies the configured polarity.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         an_out        <= {NUM_DIGITS{AN_ACTIVE_LOW}};
         cat_out       <= {7{SEG_ACTIVE_LOW}};
         dp_out        <= SEG_ACTIVE_LOW;
         scan_wrap_out <= 1'b0;
      end else begin
         an_out        <= guard_s ? {NUM_DIGITS{AN_ACTIVE_LOW}}
                                  : (an_sel_s ^ {NUM_DIGITS{AN_ACTIVE_LOW}});
         cat_out       <= seg_s ^ {7{SEG_ACTIVE_LOW}};
         dp_out        <= (dp_sel_s & ~dark_s) ^ SEG_ACTIVE_LOW;
         scan_wrap_out <= wrap_r;
      end
   end

endmodule
